// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin arbiter and one-command-at-a-time sequencer in front of
// a single-port SRAM with registered read data.
module sram_arb_ctrl #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DEPTH_LOG = $clog2(DEPTH),
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [2*DEPTH_LOG-1:0] req_addr,
  input  logic [2*WIDTH-1:0]     req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [WIDTH-1:0]       rsp_rdata,
  output logic                   busy,
  output logic [2*CNT_W-1:0]     done_cnt,
  output logic                   chip_select,
  output logic                   write_enable,
  output logic [DEPTH_LOG-1:0]   address,
  output logic [WIDTH-1:0]       data_in,
  input  logic [WIDTH-1:0]       data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RD_RESP} state_t;

  state_t               state, state_n;
  logic                 last_grant, last_grant_d;
  logic                 port_q, port_d;
  logic                 we_q, we_lat_d;
  logic [1:0]           hs;
  logic                 sel;
  logic                 cs_d, wen_d;
  logic [DEPTH_LOG-1:0] addr_d;
  logic [WIDTH-1:0]     din_d;
  logic [1:0]           rsp_valid_d;
  logic [WIDTH-1:0]     rdata_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Arbitration: at most one ready bit, only in IDLE; ties go to the port not granted last
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && !reset) begin
      case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = last_grant ? 2'b01 : 2'b10;
        default: req_ready = 2'b00;
      endcase
    end
  end

  assign hs  = req_valid & req_ready;
  assign sel = hs[1];

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (|hs) state_n = ISSUE;
      ISSUE:   state_n = we_q ? IDLE : RD_WAIT;
      RD_WAIT: state_n = RD_RESP;
      RD_RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs and latched command fields
  always_comb begin
    cs_d         = 1'b0;
    wen_d        = 1'b0;
    addr_d       = address;
    din_d        = data_in;
    rsp_valid_d  = 2'b00;
    rdata_d      = rsp_rdata;
    port_d       = port_q;
    we_lat_d     = we_q;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (|hs) begin
          port_d       = sel;
          we_lat_d     = sel ? req_we[1] : req_we[0];
          addr_d       = sel ? req_addr[2*DEPTH_LOG-1:DEPTH_LOG] : req_addr[DEPTH_LOG-1:0];
          din_d        = sel ? req_wdata[2*WIDTH-1:WIDTH] : req_wdata[WIDTH-1:0];
          cs_d         = 1'b1;
          wen_d        = we_lat_d;
          last_grant_d = sel;
        end
      end
      ISSUE:   if (we_q) rsp_valid_d[port_q] = 1'b1;
      RD_WAIT: begin
        rdata_d             = data_out;
        rsp_valid_d[port_q] = 1'b1;
      end
      default: ;
    endcase
  end

  // Output and command registers; completion counters saturate
  always_ff @(posedge clk) begin
    if (reset) begin
      chip_select  <= 1'b0;
      write_enable <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= '0;
      busy         <= 1'b0;
      done_cnt     <= '0;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      last_grant   <= 1'b1;
    end else begin
      chip_select  <= cs_d;
      write_enable <= wen_d;
      address      <= addr_d;
      data_in      <= din_d;
      rsp_valid    <= rsp_valid_d;
      rsp_rdata    <= rdata_d;
      busy         <= (state_n != IDLE);
      port_q       <= port_d;
      we_q         <= we_lat_d;
      last_grant   <= last_grant_d;
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid_d[i] && (done_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
          done_cnt[i*CNT_W +: CNT_W] <= done_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Directed bench for sram_arb_ctrl with a behavioural single-port SRAM.
module tb_sram_arb_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0]  req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0] rsp_rdata, data_in, data_out;
  logic             busy, chip_select, write_enable;
  logic [2*CNT_W-1:0] done_cnt;
  logic [AW-1:0]    address;
  logic [WIDTH-1:0] mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  sram_arb_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy), .done_cnt(done_cnt),
    .chip_select(chip_select), .write_enable(write_enable), .address(address),
    .data_in(data_in), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: registered read, write on select
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    data_out = '0;
  end
  always @(posedge clk) begin
    if (chip_select) begin
      if (write_enable) mem[address] <= data_in;
      else              data_out     <= mem[address];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a command on port p and wait (bounded) until it is accepted
  task automatic present(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [WIDTH-1:0] d, output int waits);
    req_valid[p] = 1'b1;
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*WIDTH +: WIDTH] = d;
    #1;
    waits = 0;
    while (!req_ready[p] && waits < 20) begin
      tick();
      waits++;
    end
    check("accept_ready", 64'(req_ready), 64'(2'b01 << p));
    tick();
    req_valid[p] = 1'b0;
  endtask

  task automatic do_write(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    int w;
    present(p, 1'b1, a, d, w);
    check("wr_issue_cs", 64'(chip_select), 64'(1));
    check("wr_issue_we", 64'(write_enable), 64'(1));
    check("wr_issue_addr", 64'(address), 64'(a));
    check("wr_issue_data", 64'(data_in), 64'(d));
    check("wr_issue_rsp", 64'(rsp_valid), 64'(0));
    tick();
    check("wr_ack_rsp", 64'(rsp_valid), 64'(2'b01 << p));
    check("wr_ack_cs", 64'(chip_select), 64'(0));
    check("wr_ack_busy", 64'(busy), 64'(0));
  endtask

  task automatic do_read(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp,
                         output int waits);
    present(p, 1'b0, a, '0, waits);
    check("rd_issue_cs", 64'(chip_select), 64'(1));
    check("rd_issue_we", 64'(write_enable), 64'(0));
    check("rd_issue_addr", 64'(address), 64'(a));
    tick();
    check("rd_wait_cs", 64'(chip_select), 64'(0));
    check("rd_wait_rsp", 64'(rsp_valid), 64'(0));
    check("rd_wait_busy", 64'(busy), 64'(1));
    tick();
    check("rd_resp_rsp", 64'(rsp_valid), 64'(2'b01 << p));
    check("rd_resp_data", 64'(rsp_rdata), 64'(exp));
  endtask

  initial begin
    int n, gidx, k, gp;
    reset = 1'b1;
    req_valid = 2'b11;
    req_we = 2'b00;
    req_addr = '0;
    req_wdata = '0;

    // Reset held with both ports requesting
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_cs", 64'(chip_select), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_cnt", 64'(done_cnt), 64'(0));
      check("rst_rsp", 64'(rsp_valid), 64'(0));
    end
    req_valid = 2'b00;
    reset = 1'b0;
    tick();

    // Port 0 writes 10+i to addr i
    for (int i = 0; i < 8; i++) do_write(0, AW'(i), WIDTH'(10 + i));
    tick();
    for (int i = 0; i < 8; i++) check("mem_after_wr", 64'(mem[i]), 64'(10 + i));
    check("cnt0_after_wr", 64'(done_cnt[CNT_W-1:0]), 64'(8));

    // Port 1 reads back
    for (int i = 0; i < 8; i++) do_read(1, AW'(i), WIDTH'(10 + i), n);
    tick();
    check("cnt1_after_rd", 64'(done_cnt[2*CNT_W-1:CNT_W]), 64'(8));
    check("cnt0_unchanged", 64'(done_cnt[CNT_W-1:0]), 64'(8));

    // Contention: port 0 writes A0+k to addr k, port 1 reads addr 7
    k = 0;
    gidx = 0;
    req_we = 2'b01;
    req_addr = {AW'(7), AW'(0)};
    req_wdata = {WIDTH'(0), WIDTH'(32'hA0)};
    req_valid = 2'b11;
    #1;
    for (int cyc = 0; cyc < 80 && gidx < 8; cyc++) begin
      gp = -1;
      check("cont_onehot", 64'(req_ready == 2'b11), 64'(0));
      if (rsp_valid[1]) check("cont_rdata", 64'(rsp_rdata), 64'(17));
      if (req_ready != 2'b00) begin
        check("cont_grant", 64'(req_ready), 64'(2'b01 << (gidx % 2)));
        gp = req_ready[1] ? 1 : 0;
        gidx++;
      end
      tick();
      if (gp == 0) begin
        k++;
        req_addr[AW-1:0] = AW'(k);
        req_wdata[WIDTH-1:0] = WIDTH'(32'hA0 + k);
      end
      if (gidx == 8) req_valid = 2'b00;
    end
    check("cont_grants", 64'(gidx), 64'(8));
    for (int c = 0; c < 4; c++) tick();
    for (int i = 0; i < 4; i++) check("cont_mem", 64'(mem[i]), 64'(32'hA0 + i));
    check("cont_cnt0", 64'(done_cnt[CNT_W-1:0]), 64'(12));
    check("cont_cnt1", 64'(done_cnt[2*CNT_W-1:CNT_W]), 64'(12));

    // Back-to-back: write then immediate read of the same address on port 0
    do_write(0, AW'(6), WIDTH'(32'h55));
    do_read(0, AW'(6), WIDTH'(32'h55), n);
    check("b2b_no_wait", 64'(n), 64'(0));
    tick();
    check("b2b_cnt0", 64'(done_cnt[CNT_W-1:0]), 64'(14));

    // Reset during RD_WAIT of a port 1 read
    present(1, 1'b0, AW'(5), '0, n);
    tick();
    check("abort_rdwait_busy", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_rsp", 64'(rsp_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_cnt", 64'(done_cnt), 64'(0));
    check("abort_cs", 64'(chip_select), 64'(0));
    tick();
    check("abort_rsp_after", 64'(rsp_valid), 64'(0));
    check("abort_busy_after", 64'(busy), 64'(0));
    do_read(1, AW'(5), WIDTH'(15), n);
    tick();
    check("abort_cnt1", 64'(done_cnt[2*CNT_W-1:CNT_W]), 64'(1));
    check("abort_cnt0", 64'(done_cnt[CNT_W-1:0]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
